// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the execute-stage ALU and the multiply/divide unit.
// Holds mduOp codes, default MDU latencies, FSM states and op-class helpers.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    // Codes 9-15 are treated as "no operation".
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // mult/multu/div/divu: ops that start a busy period
    function automatic logic mdu_is_long(input logic [3:0] op);
        return (op >= MDU_MULT) && (op <= MDU_DIVU);
    endfunction

    function automatic logic mdu_is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // any op that touches the unit when qualified by start
    function automatic logic mdu_is_op(input logic [3:0] op);
        return (op >= MDU_MULT) && (op <= MDU_MTLO);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline-side bundle for the multiply/divide unit.
// master: execute stage (drives A/B/mduOp/start); slave: mdu_ctrl.
interface mdu_ctrl_if;

    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  mduOp;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] R;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output A, B, mduOp, start,
        input  busy, stall, R, hi, lo
    );

    modport slave (
        input  A, B, mduOp, start,
        output busy, stall, R, hi, lo
    );

endinterface

// File: rtl/mdu_calc.sv
// Combinational 64-bit result for mult/multu/div/divu on latched operands.
// Ports: a_i, b_i operands; op_i mduOp; res_o = {hi_next, lo_next}.
module mdu_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  op_i,
    output logic [63:0] res_o
);

    logic        sgn;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] quo_m;
    logic [31:0] rem_m;
    logic [31:0] quo;
    logic [31:0] rem;

    assign sgn = (op_i == MDU_MULT) || (op_i == MDU_DIV);

    // One multiplier: sign- or zero-extend, keep the low 64 bits.
    assign a_ext = sgn ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
    assign b_ext = sgn ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
    assign prod  = a_ext * b_ext;

    // One unsigned divider on magnitudes; signs restored afterwards.
    // 0x80000000 keeps its own magnitude, so MIN/-1 yields 0x80000000.
    assign mag_a = a_i[31] ? -a_i : a_i;
    assign mag_b = b_i[31] ? -b_i : b_i;
    assign num   = sgn ? mag_a : a_i;
    // divide by zero result is discarded by the controller
    assign den   = (b_i == 32'd0) ? 32'd1 : (sgn ? mag_b : b_i);
    assign quo_m = num / den;
    assign rem_m = num % den;
    assign quo   = (sgn && (a_i[31] ^ b_i[31])) ? -quo_m : quo_m;
    assign rem   = (sgn && a_i[31]) ? -rem_m : rem_m;

    always_comb begin
        res_o = '0;
        unique case (1'b1)
            (op_i == MDU_MULT),
            (op_i == MDU_MULTU): res_o = prod;
            (op_i == MDU_DIV),
            (op_i == MDU_DIVU):  res_o = {rem, quo};
            default:             res_o = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: IDLE/BUSY FSM, latency counter, HI/LO.
// Ports: clk, reset_n (async, active-low); bus (slave) carries A, B, mduOp,
// start in and busy, stall, R (mfhi/mflo data), hi, lo out.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    mdu_ctrl_if.slave   bus
);

    localparam int unsigned MAXC =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW = $clog2(MAXC + 1);

    mdu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] res;

    mdu_calc u_calc (
        .a_i   (a_q),
        .b_i   (b_q),
        .op_i  (op_q),
        .res_o (res)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            MDU_IDLE: begin
                if (bus.start) begin
                    unique case (1'b1)
                        mdu_is_long(bus.mduOp): begin
                            a_d     = bus.A;
                            b_d     = bus.B;
                            op_d    = bus.mduOp;
                            cnt_d   = mdu_is_div(bus.mduOp) ?
                                      CW'(DIV_CYCLES) :
                                      CW'(MULT_CYCLES);
                            state_d = MDU_BUSY;
                        end
                        (bus.mduOp == MDU_MTHI): hi_d = bus.A;
                        (bus.mduOp == MDU_MTLO): lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            MDU_BUSY: begin
                // start is ignored here; operands stay latched
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = MDU_IDLE;
                    // divide by zero leaves HI/LO untouched
                    if (!(mdu_is_div(op_q) && (b_q == 32'd0))) begin
                        hi_d = res[63:32];
                        lo_d = res[31:0];
                    end
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    assign bus.busy  = (state_q == MDU_BUSY);
    assign bus.stall = bus.busy | (bus.start & mdu_is_op(bus.mduOp));
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    always_comb begin
        bus.R = '0;
        unique case (1'b1)
            (bus.mduOp == MDU_MFHI): bus.R = hi_q;
            (bus.mduOp == MDU_MFLO): bus.R = lo_q;
            default:                 bus.R = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed cases plus random op stream.
// Driver pushes expected HI/LO/latency; a negedge monitor checks completions.
module tb_mdu_ctrl;

    logic clk;
    logic reset_n;

    mdu_ctrl_if bus ();

    mdu_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t scb[$];
    int   cmp_n = 0;
    int   err_n = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, pu, qu, ru;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            4'd2: begin
                pu = ua * ub;
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            4'd3: if (b != 32'd0) begin
                q = sa / sb;
                r = sa % sb;
                m_hi = r[31:0];
                m_lo = q[31:0];
            end
            4'd4: if (b != 32'd0) begin
                qu = ua / ub;
                ru = ua % ub;
                m_hi = ru[31:0];
                m_lo = qu[31:0];
            end
            4'd7: m_hi = a;
            4'd8: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: counts busy cycles; on busy falling pops and compares.
    initial begin
        int   n;
        exp_t e;
        n = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                n = 0;
            end else if (bus.busy) begin
                n++;
            end else if (n > 0) begin
                if (scb.size() == 0) begin
                    chk("unexpected_completion", 32'(n), 32'd0);
                end else begin
                    e = scb.pop_front();
                    chk("result_hi", bus.hi, e.hi);
                    chk("result_lo", bus.lo, e.lo);
                    chk("busy_cycles", 32'(n), 32'(e.lat));
                end
                n = 0;
            end
        end
    end

    task automatic long_op(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit inject);
        int   k;
        exp_t e;
        bus.A     = a;
        bus.B     = b;
        bus.mduOp = op;
        bus.start = 1'b1;
        #1;
        chk("stall_issue", 32'(bus.stall), 32'd1);
        model_op(op, a, b);
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.lat = (op <= 4'd2) ? 5 : 10;
        scb.push_back(e);
        tick();
        bus.start = 1'b0;
        bus.mduOp = 4'd0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        for (k = 0; k < 40; k++) begin
            if (!bus.busy) break;
            if (inject && k == 1) begin
                bus.mduOp = 4'd2;
                bus.start = 1'b1;
                #1;
            end else begin
                bus.mduOp = 4'd0;
                bus.start = 1'b0;
            end
            chk("stall_busy", 32'(bus.stall), 32'd1);
            tick();
        end
        bus.start = 1'b0;
        bus.mduOp = 4'd0;
        if (k == 40) chk("busy_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic mt_op(input logic [3:0] op, input logic [31:0] a);
        bus.A     = a;
        bus.mduOp = op;
        bus.start = 1'b1;
        #1;
        chk("mt_stall", 32'(bus.stall), 32'd1);
        model_op(op, a, 32'd0);
        tick();
        bus.start = 1'b0;
        bus.mduOp = 4'd0;
        chk("mt_busy", 32'(bus.busy), 32'd0);
        chk("mt_hi", bus.hi, m_hi);
        chk("mt_lo", bus.lo, m_lo);
    endtask

    task automatic check_r();
        bus.start = 1'b0;
        bus.mduOp = 4'd5;
        #1;
        chk("mfhi_R", bus.R, m_hi);
        bus.mduOp = 4'd6;
        #1;
        chk("mflo_R", bus.R, m_lo);
        bus.mduOp = 4'd9;
        #1;
        chk("none_R", bus.R, 32'd0);
        bus.mduOp = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int          sel;
        reset_n   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.mduOp = '0;
        bus.start = 1'b0;
        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        long_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        chk("mult_hi", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo, 32'hFFFFFFFA);
        tick();

        long_op(4'd4, 32'd7, 32'd2, 1'b0);
        chk("divu_hi", bus.hi, 32'd1);
        chk("divu_lo", bus.lo, 32'd3);
        tick();
        long_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div_hi", bus.hi, 32'hFFFFFFFF);
        chk("div_lo", bus.lo, 32'hFFFFFFFD);
        tick();

        mt_op(4'd7, 32'h1234);
        mt_op(4'd8, 32'h5678);
        long_op(4'd3, 32'h99, 32'd0, 1'b0);
        chk("div0_hi", bus.hi, 32'h1234);
        chk("div0_lo", bus.lo, 32'h5678);
        tick();

        long_op(4'd1, 32'd1000, 32'hFFFFFFFD, 1'b1);
        chk("inject_lo", bus.lo, 32'hFFFFF448);
        tick();

        long_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("ovf_hi", bus.hi, 32'd0);
        chk("ovf_lo", bus.lo, 32'h80000000);
        tick();

        // reset in the middle of a div
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        bus.mduOp = 4'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mduOp = 4'd0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("postrst_hi", bus.hi, 32'd0);
        chk("postrst_lo", bus.lo, 32'd0);
        chk("postrst_busy", 32'(bus.busy), 32'd0);
        long_op(4'd1, 32'd12, 32'd13, 1'b0);
        chk("postrst_mult", bus.lo, 32'd156);
        tick();

        mt_op(4'd8, 32'hDEADBEEF);
        bus.mduOp = 4'd6;
        #1;
        chk("mflo_R", bus.R, 32'hDEADBEEF);
        tick();
        bus.A     = 32'd3;
        bus.B     = 32'd4;
        bus.mduOp = 4'd2;
        bus.start = 1'b1;
        model_op(4'd2, 32'd3, 32'd4);
        scb.push_back('{hi: m_hi, lo: m_lo, lat: 5});
        tick();
        bus.mduOp = 4'd6;
        bus.start = 1'b1;
        #1;
        chk("mflo_busy_stall", 32'(bus.stall), 32'd1);
        chk("mflo_busy_R", bus.R, 32'hDEADBEEF);
        bus.start = 1'b0;
        for (int i = 0; i < 20 && bus.busy; i++) tick();
        bus.mduOp = 4'd0;
        tick();
        check_r();

        for (int it = 0; it < 30; it++) begin
            tick();
            sel = $urandom_range(0, 9);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3))
                                            : $urandom;
            case (sel)
                0, 1: long_op(4'd1, a, b, 1'b0);
                2:    long_op(4'd2, a, b, 1'b0);
                3, 4: long_op(4'd3, a, b, 1'b0);
                5:    long_op(4'd4, a, b, 1'b0);
                6:    mt_op(4'd7, a);
                7:    mt_op(4'd8, a);
                8: begin
                    bus.A     = a;
                    bus.mduOp = 4'(9 + $urandom_range(0, 6));
                    bus.start = 1'b1;
                    #1;
                    chk("none_stall", 32'(bus.stall), 32'd0);
                    tick();
                    bus.start = 1'b0;
                    bus.mduOp = 4'd0;
                    chk("none_busy", 32'(bus.busy), 32'd0);
                end
                default: long_op(4'd3, a, 32'd0, 1'b0);
            endcase
            check_r();
        end

        tick();
        tick();
        chk("scb_empty", 32'(scb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_n, err_n);
        $finish;
    end

endmodule
